word_memory: RTL and testbench

WORD_MEMORY -- requirements
Module: word_memory

---
 rtl/word_memory_pkg.sv | 12 +
 rtl/word_memory_word_register.sv | 41 ++++
 rtl/word_memory.sv | 121 ++++++++++++
 tb/tb_word_memory.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/word_memory_pkg.sv
// Shared encodings for the word_memory block: operation codes and sweep FSM states.
package word_memory_pkg;

  localparam logic [1:0] OP_NOP       = 2'b00;
  localparam logic [1:0] OP_STORE     = 2'b01;
  localparam logic [1:0] OP_FLIP      = 2'b10;
  localparam logic [1:0] OP_CLEAR_ALL = 2'b11;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

endpackage

// File: rtl/word_memory_word_register.sv
// One stored word: clear has priority over store, otherwise the flip mask is XORed in
// (an all-zero mask simply holds the value).
module word_register #(
  parameter int BIT_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 store_en_i,
  input  logic [BIT_COUNT-1:0] store_data_i,
  input  logic [BIT_COUNT-1:0] flip_mask_i,
  input  logic                 clear_i,
  output logic [BIT_COUNT-1:0] word_o
);

  logic [BIT_COUNT-1:0] word_d;
  logic [BIT_COUNT-1:0] word_q;

  // next-state select for the stored word
  always_comb begin
    word_d = word_q;
    if (clear_i) begin
      word_d = {BIT_COUNT{1'b0}};
    end else if (store_en_i) begin
      word_d = store_data_i;
    end else begin
      word_d = word_q ^ flip_mask_i;
    end
  end

  // word storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= {BIT_COUNT{1'b0}};
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/word_memory.sv
// Small word memory with store/flip ops, a one-word-per-cycle CLEAR_ALL sweep and a
// registered single-cycle read port that returns pre-edge data.
module word_memory
  import word_memory_pkg::*;
#(
  parameter int BIT_COUNT  = 8,
  parameter int WORD_COUNT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_valid,
  input  logic [1:0]                    op,
  input  logic [$clog2(WORD_COUNT)-1:0] addr,
  input  logic [BIT_COUNT-1:0]          data,
  output logic                          busy,
  input  logic                          rd_en,
  input  logic [$clog2(WORD_COUNT)-1:0] rd_addr,
  output logic [BIT_COUNT-1:0]          rd_data,
  output logic                          rd_valid
);

  localparam int ADDR_WIDTH = $clog2(WORD_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_COUNT - 1);

  logic                  state_d, state_q;
  logic [ADDR_WIDTH-1:0] k_d, k_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  accept_s;
  logic [BIT_COUNT-1:0]  rd_word_s;
  logic [BIT_COUNT-1:0]  rd_data_d, rd_data_q;
  logic                  rd_valid_d, rd_valid_q;

  logic [BIT_COUNT-1:0]  words_s     [WORD_COUNT];
  logic [BIT_COUNT-1:0]  flip_mask_s [WORD_COUNT];
  logic [WORD_COUNT-1:0] store_en_s;
  logic [WORD_COUNT-1:0] clear_s;

  // ready_q blocks op acceptance on the first edge after reset release
  assign accept_s = op_valid && (state_q == ST_IDLE) && ready_q;

  for (genvar i = 0; i < WORD_COUNT; i++) begin : g_word
    logic sel_s;
    assign sel_s          = (addr == ADDR_WIDTH'(i));
    assign store_en_s[i]  = accept_s && (op == OP_STORE) && sel_s;
    assign flip_mask_s[i] = (accept_s && (op == OP_FLIP) && sel_s) ? data : {BIT_COUNT{1'b0}};
    assign clear_s[i]     = (state_q == ST_CLEAR) && (k_q == ADDR_WIDTH'(i));

    word_register #(.BIT_COUNT(BIT_COUNT)) u_word (
      .clk          (clk),
      .rst_n        (rst_n),
      .store_en_i   (store_en_s[i]),
      .store_data_i (data),
      .flip_mask_i  (flip_mask_s[i]),
      .clear_i      (clear_s[i]),
      .word_o       (words_s[i])
    );
  end

  // sweep FSM and index
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (op == OP_CLEAR_ALL)) begin
          state_d = ST_CLEAR;
          k_d     = {ADDR_WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (k_q == LAST_IDX) begin
          state_d = ST_IDLE;
          k_d     = {ADDR_WIDTH{1'b0}};
        end else begin
          k_d = k_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // read mux; indices with no word fall through to zero
  always_comb begin
    rd_word_s = {BIT_COUNT{1'b0}};
    for (int i = 0; i < WORD_COUNT; i++) begin
      rd_word_s = rd_word_s | (words_s[i] & {BIT_COUNT{rd_addr == ADDR_WIDTH'(i)}});
    end
    rd_data_d  = rd_en ? rd_word_s : rd_data_q;
    rd_valid_d = rd_en;
  end

  // control and read registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= {ADDR_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      rd_data_q  <= {BIT_COUNT{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      busy_q     <= (state_d == ST_CLEAR);
      ready_q    <= 1'b1;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_word_memory.sv
// Self-checking bench for word_memory: directed vector table, hand sequences for the
// sweep/reset corners, a WORD_COUNT=3 build, and random traffic against a behavioural model.
module tb_word_memory;
  import word_memory_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic [1:0] op;
  logic [1:0] addr;
  logic [7:0] data;
  logic       busy;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;

  logic       op_valid3;
  logic [1:0] op3;
  logic [1:0] addr3;
  logic [7:0] data3;
  logic       busy3;
  logic       rd_en3;
  logic [1:0] rd_addr3;
  logic [7:0] rd_data3;
  logic       rd_valid3;

  int checks = 0;
  int errors = 0;

  word_memory #(.BIT_COUNT(8), .WORD_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .addr(addr), .data(data),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  word_memory #(.BIT_COUNT(8), .WORD_COUNT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid3), .op(op3), .addr(addr3), .data(data3),
    .busy(busy3), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3), .rd_valid(rd_valid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model of the 4-word instance
  logic [7:0] m_mem [4];
  int         m_clr_left;
  int         m_clr_idx;
  bit         m_ready;
  logic [7:0] m_rd_data;
  logic       m_rd_valid;

  typedef struct {
    logic       ov;
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] data;
    logic       re;
    logic [1:0] ra;
    logic [7:0] e_rd;
    logic       e_rv;
    logic       e_busy;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    m_clr_left = 0;
    m_clr_idx  = 0;
    m_ready    = 1'b0;
    m_rd_data  = 8'h00;
    m_rd_valid = 1'b0;
  endtask

  // one rising edge of the reference: read old contents, then apply sweep or op
  task automatic model_edge();
    if (rd_en) m_rd_data = m_mem[rd_addr];
    m_rd_valid = rd_en;
    if (m_clr_left > 0) begin
      m_mem[m_clr_idx] = 8'h00;
      m_clr_idx++;
      m_clr_left--;
    end else if (m_ready && op_valid) begin
      case (op)
        OP_STORE:     m_mem[addr] = data;
        OP_FLIP:      m_mem[addr] = m_mem[addr] ^ data;
        OP_CLEAR_ALL: begin m_clr_left = 4; m_clr_idx = 0; end
        default: ;
      endcase
    end
    m_ready = 1'b1;
  endtask

  task automatic set_op(logic v, logic [1:0] o, logic [1:0] a, logic [7:0] d,
                        logic re, logic [1:0] ra);
    op_valid = v;
    op       = o;
    addr     = a;
    data     = d;
    rd_en    = re;
    rd_addr  = ra;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(m_clr_left > 0));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    chk("rd_data", 32'(rd_data), 32'(m_rd_data));
  endtask

  task automatic read_word(logic [1:0] a, logic [7:0] exp, string name);
    set_op(1'b0, OP_NOP, 2'd0, 8'h00, 1'b1, a);
    tick();
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  // asynchronous reset pulse between edges, checked before the next edge
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic tick3(logic v, logic [1:0] o, logic [1:0] a, logic [7:0] d,
                       logic re, logic [1:0] ra);
    op_valid3 = v; op3 = o; addr3 = a; data3 = d; rd_en3 = re; rd_addr3 = ra;
    set_op(1'b0, OP_NOP, 2'd0, 8'h00, 1'b0, 2'd0);
    tick();
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, OP_STORE, 2'd0, 8'hEE, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, OP_STORE, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, OP_NOP,   2'd0, 8'h00, 1'b1, 2'd2, 8'hA5, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, OP_NOP,   2'd0, 8'h00, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, OP_STORE, 2'd1, 8'hF0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, OP_FLIP,  2'd1, 8'h3C, 1'b1, 2'd1, 8'hF0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, OP_NOP,   2'd0, 8'h00, 1'b1, 2'd1, 8'hCC, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, OP_FLIP,  2'd1, 8'h3C, 1'b0, 2'd0, 8'hCC, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_NOP,   2'd0, 8'h00, 1'b1, 2'd1, 8'hF0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, OP_NOP,   2'd0, 8'h00, 1'b1, 2'd3, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, OP_STORE, 2'd3, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b1, OP_STORE, 2'd3, 8'h5A, 1'b1, 2'd3, 8'h77, 1'b1, 1'b0};
    vecs[12] = '{1'b0, OP_NOP,   2'd0, 8'h00, 1'b1, 2'd3, 8'h5A, 1'b1, 1'b0};
    vecs[13] = '{1'b0, OP_NOP,   2'd0, 8'h00, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    set_op(1'b0, OP_NOP, 2'd0, 8'h00, 1'b0, 2'd0);
    op_valid3 = 1'b0; op3 = OP_NOP; addr3 = 2'd0; data3 = 8'h00; rd_en3 = 1'b0; rd_addr3 = 2'd0;
    model_reset();
    #3;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_rd_valid", 32'(rd_valid), 32'd0);
    chk("init_rd_data", 32'(rd_data), 32'd0);
    #10 rst_n = 1'b1;

    // directed table; vector 0 lands on the first edge after reset and must be dropped
    for (int i = 0; i < NV; i++) begin
      set_op(vecs[i].ov, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].re, vecs[i].ra);
      tick();
      chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end

    // CLEAR_ALL sweep: exact busy length, stores ignored, reads serviced while busy
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, OP_STORE, 2'(i), 8'hFF, 1'b0, 2'd0);
      tick();
    end
    set_op(1'b1, OP_CLEAR_ALL, 2'd0, 8'h00, 1'b0, 2'd0);
    tick();
    n = 0;
    while (busy && n < 10) begin
      set_op(1'b1, OP_STORE, 2'd0, 8'h11, 1'b1, 2'(n));
      tick();
      n++;
    end
    chk("clear_busy_cycles", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) read_word(2'(i), 8'h00, $sformatf("after_clear_w%0d", i));

    // reset during the sweep, then first post-reset op dropped, second accepted
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, OP_STORE, 2'(i), 8'hFF, 1'b0, 2'd0);
      tick();
    end
    set_op(1'b1, OP_CLEAR_ALL, 2'd0, 8'h00, 1'b0, 2'd0);
    tick();
    set_op(1'b0, OP_NOP, 2'd0, 8'h00, 1'b0, 2'd0);
    tick();
    reset_pulse();
    set_op(1'b1, OP_STORE, 2'd2, 8'h24, 1'b0, 2'd0);
    tick();
    set_op(1'b1, OP_STORE, 2'd1, 8'h42, 1'b0, 2'd0);
    tick();
    read_word(2'd1, 8'h42, "post_rst_store");
    read_word(2'd2, 8'h00, "post_rst_first_edge_dropped");
    read_word(2'd3, 8'h00, "post_rst_word3");

    // WORD_COUNT=3 instance: out-of-range store and read
    tick3(1'b1, OP_STORE, 2'd3, 8'h99, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick3(1'b0, OP_NOP, 2'd0, 8'h00, 1'b1, 2'(i));
      chk($sformatf("wc3_rd_data_%0d", i), 32'(rd_data3), 32'd0);
      chk($sformatf("wc3_rd_valid_%0d", i), 32'(rd_valid3), 32'd1);
    end
    tick3(1'b1, OP_STORE, 2'd2, 8'h99, 1'b0, 2'd0);
    tick3(1'b0, OP_NOP, 2'd0, 8'h00, 1'b1, 2'd2);
    chk("wc3_store2", 32'(rd_data3), 32'h99);
    chk("wc3_busy", 32'(busy3), 32'd0);
    tick3(1'b0, OP_NOP, 2'd0, 8'h00, 1'b0, 2'd0);
    chk("wc3_rd_valid_idle", 32'(rd_valid3), 32'd0);

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      set_op(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
